// File: rtl/bcd_to_bin_converter_pkg.sv
// Shared constants, FSM state type and digit helper for the BCD-to-binary converter.
package bcd_to_bin_converter_pkg;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0]  BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0]  BCD_ADJ_VAL    = 4'd3;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOp   = 2'b01,
        StDone = 2'b10
    } conv_state_e;

    // A nibble above 9 is not a decimal digit.
    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_to_bin_converter_digit_adjust.sv
// Per-digit correction for reverse double-dabble: digits >= 8 lose 3 after the shift.
module bcd_digit_adjust
    import bcd_to_bin_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Only applied at >= 8, so the 4-bit subtraction cannot wrap.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i - BCD_ADJ_VAL;
        end
    end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one operand in flight.
module bcd_to_bin_converter
    import bcd_to_bin_converter_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [BCD_DIGIT_W*N-1:0] bcd_in,
    output logic                     ready,
    output logic                     done_tick,
    output logic [W-1:0]             bin_out,
    output logic                     err
);

    localparam int unsigned BcdW = BCD_DIGIT_W * N;
    localparam int unsigned CntW = $clog2(W + 1);

    conv_state_e     state_q;
    logic [BcdW-1:0] bcd_q;
    logic [W-1:0]    bin_q;
    logic [CntW-1:0] cnt_q;
    logic            err_reg_q;
    logic            ready_q;
    logic            done_tick_q;
    logic [W-1:0]    bin_out_q;
    logic            err_q;

    logic [BcdW+W-1:0] cat_shift;
    logic [BcdW-1:0]   bcd_shift;
    logic [BcdW-1:0]   bcd_adj;
    logic [W-1:0]      bin_shift;
    logic              any_bad;

    // Flag an operand containing any non-decimal nibble.
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            any_bad = any_bad | digit_invalid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    // One reverse double-dabble step: shift the {bcd, bin} pair right by one.
    always_comb begin
        cat_shift = {bcd_q, bin_q} >> 1;
        bcd_shift = cat_shift[BcdW+W-1:W];
        bin_shift = cat_shift[W-1:0];
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            err_reg_q   <= 1'b0;
            ready_q     <= 1'b1;
            done_tick_q <= 1'b0;
            bin_out_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            done_tick_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        bcd_q     <= bcd_in;
                        bin_q     <= '0;
                        err_reg_q <= any_bad;
                        cnt_q     <= CntW'(W);
                        ready_q   <= 1'b0;
                        state_q   <= StOp;
                    end else begin
                        state_q   <= StIdle;
                    end
                end
                StOp: begin
                    bcd_q <= bcd_adj;
                    bin_q <= bin_shift;
                    cnt_q <= cnt_q - CntW'(1);
                    // Last shift: publish the result as the FSM enters DONE.
                    if (cnt_q == CntW'(1)) begin
                        state_q     <= StDone;
                        ready_q     <= 1'b1;
                        done_tick_q <= 1'b1;
                        bin_out_q   <= err_reg_q ? '0 : bin_shift;
                        err_q       <= err_reg_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign done_tick = done_tick_q;
    assign bin_out   = bin_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Self-checking bench for bcd_to_bin_converter: decimal model plus directed vectors.
module tb_bcd_to_bin_converter;

    localparam int N = 3;
    localparam int W = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        ready;
    logic        done_tick;
    logic [9:0]  bin_out;
    logic        err;

    int checks = 0;
    int failures = 0;

    bcd_to_bin_converter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .ready     (ready),
        .done_tick (done_tick),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Decimal value of a packed BCD word; bad set if any nibble exceeds 9.
    function automatic int bcd_value(input logic [11:0] b, output bit bad);
        int v;
        logic [3:0] dig;
        v = 0;
        bad = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            dig = b[4*i +: 4];
            if (dig > 4'd9) bad = 1'b1;
            v = v * 10 + int'(dig);
        end
        return v;
    endfunction

    // Behavioural model: accepted start at edge k yields a result after edge k+W.
    int e = 0;
    int m_end = 0;
    int p_val = 0;
    int m_bin = 0;
    bit p_err = 1'b0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_err = 1'b0;
    bit was_busy = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_bin  = 0;
                m_err  = 1'b0;
            end else begin
                e++;
                was_busy = m_busy;
                m_done = 1'b0;
                if (m_busy && e == m_end) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bin  = p_err ? 0 : p_val;
                    m_err  = p_err;
                end
                if (!was_busy && start) begin
                    p_val  = bcd_value(bcd_in, p_err);
                    m_busy = 1'b1;
                    m_end  = e + W;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_ready", int'(ready), int'(!m_busy));
            chk("model_done_tick", int'(done_tick), int'(m_done));
            chk("model_bin_out", int'(bin_out), m_bin);
            chk("model_err", int'(err), int'(m_err));
        end
    end

    // Single conversion with literal expectations on latency and result.
    task automatic run(input string tag, input logic [11:0] b, input int exp_bin,
                       input int exp_err);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, int'(ready), 1);
        start  = 1'b1;
        bcd_in = b;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done_tick && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 11);
        chk({tag, "_bin"}, int'(bin_out), exp_bin);
        chk({tag, "_err"}, int'(err), exp_err);
    endtask

    int ndone;
    int n;

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done_tick", int'(done_tick), 0);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_err", int'(err), 0);

        run("c999", 12'h999, 999, 0);
        run("c000", 12'h000, 0, 0);
        run("c512", 12'h512, 512, 0);
        run("c100", 12'h100, 100, 0);
        run("c1A5", 12'h1A5, 0, 1);
        run("c042", 12'h042, 42, 0);

        // Starts while busy must be ignored.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h250;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i <= 10) chk("ign_ready_low", int'(ready), 0);
            if (i == 11) chk("ign_ready_done", int'(ready), 1);
            if (done_tick) begin
                ndone++;
                if (ndone == 1) begin
                    chk("ign_latency", i, 11);
                    chk("ign_bin", int'(bin_out), 250);
                end
            end
            if (i == 3 || i == 7) begin
                start  = 1'b1;
                bcd_in = 12'h777;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_done_count", ndone, 1);

        // Back-to-back: start held, new operand presented in DONE.
        start  = 1'b1;
        bcd_in = 12'h123;
        @(negedge clk);
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            if (done_tick) begin
                ndone++;
                if (ndone == 1) begin
                    chk("b2b_first_latency", i, 11);
                    chk("b2b_first_bin", int'(bin_out), 123);
                    bcd_in = 12'h321;
                end else if (ndone == 2) begin
                    chk("b2b_second_latency", i, 22);
                    chk("b2b_second_bin", int'(bin_out), 321);
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_done_count", ndone, 2);

        // Reset in the middle of a conversion.
        start  = 1'b1;
        bcd_in = 12'h888;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_done_tick", int'(done_tick), 0);
        chk("abort_bin", int'(bin_out), 0);
        chk("abort_err", int'(err), 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_tick) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run("c064", 12'h064, 64, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
